// File: rtl/custom_subtractor60_13_seq_pkg.sv
// Shared constants and state type for the sliced 60/13 subtractor.
package custom_sub_pkg;

    localparam int A_WIDTH    = 60;
    localparam int B_WIDTH    = 13;
    localparam int CHUNK      = 15;
    localparam int NUM_CHUNKS = A_WIDTH / CHUNK;
    // Floor of 1 keeps the index register legal for a single-slice build
    localparam int IDX_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/custom_subtractor60_13_seq_if.sv
// Issue/collect handshake bundle between a sequencer (master) and the subtractor (slave).
interface custom_subtractor60_13_seq_if #(
    parameter int A_WIDTH = custom_sub_pkg::A_WIDTH,
    parameter int B_WIDTH = custom_sub_pkg::B_WIDTH
) ();

    logic               in_valid;
    logic               in_ready;
    logic [A_WIDTH-1:0] A;
    logic [B_WIDTH-1:0] B;
    logic               out_valid;
    logic               out_ready;
    logic [A_WIDTH-1:0] Diff;
    logic               Borrow;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Diff, Borrow
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Diff, Borrow
    );

endinterface

// File: rtl/custom_subtractor60_13_seq_sub_chunk_borrow.sv
// One slice of the borrow chain: diff = a - b - borrow_in, borrow_out set on underflow.
module sub_chunk_borrow #(
    parameter int CHUNK = custom_sub_pkg::CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_borrow_in,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_borrow_out
);

    // One extra bit catches the underflow; its top bit is the borrow-out
    logic [CHUNK:0] w_full;

    assign w_full       = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_borrow_in};
    assign o_diff       = w_full[CHUNK-1:0];
    assign o_borrow_out = w_full[CHUNK];

endmodule

// File: rtl/custom_subtractor60_13_seq.sv
// Multi-cycle A - zero-extended B, one CHUNK-wide slice per cycle through a registered borrow.
module custom_subtractor60_13_seq #(
    parameter int A_WIDTH = custom_sub_pkg::A_WIDTH,
    parameter int B_WIDTH = custom_sub_pkg::B_WIDTH,
    parameter int CHUNK   = custom_sub_pkg::CHUNK
) (
    input logic                         clk,
    input logic                         rst,
    custom_subtractor60_13_seq_if.slave bus
);

    import custom_sub_pkg::*;

    localparam int              NUM_CHUNKS = A_WIDTH / CHUNK;
    localparam int              IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [A_WIDTH-1:0] r_a;
    logic [A_WIDTH-1:0] r_b;
    logic [A_WIDTH-1:0] r_diff;
    logic [IDX_W-1:0]   r_idx;
    logic               r_borrow;
    logic               r_borrow_out;

    logic [A_WIDTH-1:0] w_b_ext;
    logic [CHUNK-1:0]   w_a_slice;
    logic [CHUNK-1:0]   w_b_slice;
    logic [CHUNK-1:0]   w_slice_diff;
    logic               w_slice_borrow;
    logic               w_last;
    logic               w_in_ready;
    logic               w_out_valid;

    // Zero-extend the subtrahend to the full minuend width
    always_comb begin
        w_b_ext              = '0;
        w_b_ext[B_WIDTH-1:0] = bus.B;
    end

    // Select the current slice of both operands for the shared slice subtractor
    always_comb begin
        w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
        w_b_slice = r_b[r_idx*CHUNK +: CHUNK];
        w_last    = (r_idx == LAST_IDX);
    end

    sub_chunk_borrow #(
        .CHUNK (CHUNK)
    ) u_slice (
        .i_a          (w_a_slice),
        .i_b          (w_b_slice),
        .i_borrow_in  (r_borrow),
        .o_diff       (w_slice_diff),
        .o_borrow_out (w_slice_borrow)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept in IDLE, walk the slices in BUSY, wait for the consumer in DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next_state = BUSY;
            BUSY:    if (w_last)        w_next_state = DONE;
            DONE:    if (bus.out_ready) w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        w_in_ready  = (r_state == IDLE);
        w_out_valid = (r_state == DONE);
    end

    // Operand latch, slice write-back and borrow chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.A;
                        r_b      <= w_b_ext;
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                BUSY: begin
                    r_diff[r_idx*CHUNK +: CHUNK] <= w_slice_diff;
                    r_borrow                     <= w_slice_borrow;
                    r_idx                        <= r_idx + 1'b1;
                    if (w_last) begin
                        r_borrow_out <= w_slice_borrow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.Diff      = r_diff;
    assign bus.Borrow    = r_borrow_out;

endmodule

// File: doc/custom_subtractor60_13_seq.md
# custom_subtractor60_13_seq

Multi-cycle subtractor computing A − zero-extended B, the inverse of the 60-bit + 13-bit zero-extended add path in the ARMFlow arithmetic datapath. It processes the 60-bit operand in fixed-width slices with a registered borrow chain. This keeps the critical path to one slice, at the cost of one slice per cycle. It sits beside the 60/13 adder and uses valid/ready handshakes on both sides so a sequencer can issue and collect operations.

## Interface
Parameters:
- A_WIDTH, 60, minuend width; also the result width.
- B_WIDTH, 13, subtrahend width; zero-extended to A_WIDTH; must be ≤ A_WIDTH.
- CHUNK, 15, slice width per cycle; A_WIDTH % CHUNK must be 0.
- NUM_CHUNKS is derived as A_WIDTH/CHUNK (default 4). It is a localparam, not overridable.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  A/B valid.
- in_ready  out  1  block can accept an operation.
- A  in  A_WIDTH  minuend.
- B  in  B_WIDTH  subtrahend, unsigned.
- out_valid  out  1  Diff/Borrow valid.
- out_ready  in  1  consumer accepts the result.
- Diff  out  A_WIDTH  (A − B) mod 2^A_WIDTH.
- Borrow  out  1  1 when A < B (unsigned).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch A, and latch B zero-extended to A_WIDTH.
  - Clear the slice index and borrow register.
  - Go to BUSY.
- BUSY:
  - Slice k = [k·CHUNK +: CHUNK], with k = index.
  - Compute a_k − b_k − borrow_reg.
  - Write the result into Diff slice k; update borrow_reg from the slice borrow-out.
  - Increment the index.
  - After slice NUM_CHUNKS−1, Borrow takes the final borrow-out and the block goes to DONE.
- DONE:
  - out_valid=1.
  - Diff and Borrow are held stable.
  - On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid there is ignored, and operands are not re-latched.
- Arithmetic is unsigned with no saturation. Wrap-around is reported only via Borrow.
- Diff slices not yet computed during BUSY are don't-care; only DONE values are architectural.
- Reset in any state:
  - Next cycle: IDLE, in_ready=1, out_valid=0, Diff=0, Borrow=0, index=0, borrow_reg=0.
  - Any in-flight operation is discarded with no output.
- Simultaneous events:
  - rst has priority over every handshake.
  - The out handshake and the next in_valid never coincide, because in_ready is 0 in DONE.

## Timing
- Accept edge = cycle 0 (in_valid & in_ready).
- BUSY occupies cycles 1..NUM_CHUNKS.
- out_valid rises after the edge ending cycle NUM_CHUNKS: visible in cycle 5 for the default configuration.
- Latency from accept to out_valid is NUM_CHUNKS+1 cycles.
- Minimum issue interval is NUM_CHUNKS+2 cycles, with out_ready held high.
- in_ready returns high the cycle after the out handshake.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package custom_sub_pkg contains:
  - A_WIDTH, B_WIDTH, CHUNK, NUM_CHUNKS constants.
  - The state enum (IDLE/BUSY/DONE).
  - The index width, $clog2(NUM_CHUNKS).
- One combinational sub-module, sub_chunk_borrow:
  - Inputs: CHUNK-bit a, CHUNK-bit b, borrow_in.
  - Outputs: CHUNK-bit diff, borrow_out.
  - Instantiated once and muxed by index; no per-slice replication.

## Test plan
- A=0x000000000001000, B=0x0001, out_ready=1:
  - out_valid exactly 5 cycles after accept.
  - Diff=0x000000000000FFF, Borrow=0.
  - in_ready high the following cycle.
- A=0, B=0x0001: full borrow ripple through all 4 slices; Diff=0xFFFFFFFFFFFFFFF, Borrow=1.
- A=0x800000000000000, B=0x1FFF: Diff=0x7FFFFFFFFFFE001, Borrow=0.
- Backpressure, A=B=0x1234:
  - Hold out_ready=0 for 10 cycles.
  - Diff=0, Borrow=0 stable throughout; out_valid stays 1; in_ready stays 0.
  - in_valid pulses with A=0x5 are ignored (no re-latch).
- Reset mid-operation: assert rst in the second BUSY cycle.
  - Next cycle: in_ready=1, out_valid=0, Diff=0, Borrow=0.
  - No result is ever emitted for that operation.
- Random regression, 10k operations with random out_ready stalls:
  - Scoreboard Diff/Borrow against a 61-bit golden model.
  - Round-trip check: feed Diff and B into the 60/13 adder; its Sum[59:0] must equal A.
